// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer and flush.
// Optional stall counter output enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned CNT_W = 16;

  // State encodes the number of held entries: head valid in FULL1/FULL2, skid valid in FULL2.
  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t state, state_nx;

  logic              accept;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic              clear_ctrl;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // in_ready is a flop, so accept never depends combinationally on out_ready.
  assign accept = in_valid && in_ready;

  // Next-state and datapath load selects.
  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    case (state)
      EMPTY: begin
        if (accept) begin
          state_nx     = FULL1;
          load_main_in = 1'b1;
        end
      end
      FULL1: begin
        if (out_ready) begin
          if (accept) begin
            load_main_in = 1'b1;
          end else begin
            state_nx = EMPTY;
          end
        end else if (accept) begin
          state_nx  = FULL2;
          load_skid = 1'b1;
        end
      end
      FULL2: begin
        if (out_ready) begin
          load_main_skid = 1'b1;
          if (accept) begin
            load_skid = 1'b1;
          end else begin
            state_nx = FULL1;
          end
        end
      end
      default: begin
        state_nx = EMPTY;
      end
    endcase

    if (flush) begin
      state_nx       = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end

    clear_ctrl = (state_nx == EMPTY);
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx != EMPTY);
      in_ready  <= (state_nx != FULL2);
    end
  end

  // Head control is zeroed whenever the head goes empty so out_ctrl reads 0 on bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end else if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (clear_ctrl) begin
        main_ctrl <= '0;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = OCC_W'(state);

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of cycles where the head is held by downstream; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table plus queue scoreboard and random traffic.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 69;
  localparam int unsigned CW = 9;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0]   stall_cycles;
  logic [15:0]   stall_m;
`endif

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fl;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic [1:0]    exp_occ;
    logic          exp_rdy;
    logic [DW-1:0] exp_data;
  } vec_t;

  beat_t         q[$];
  vec_t          vecs[$];
  logic [DW-1:0] head_data;
  int            n_vec;
  int            n_err;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic void add(input int iv, input int ordy, input int fl, input int c,
                              input int d, input int occ, input int rdy, input int ed);
    vec_t v;
    v.iv       = 1'(iv);
    v.ordy     = 1'(ordy);
    v.fl       = 1'(fl);
    v.ctrl     = CW'(c);
    v.data     = DW'(d);
    v.exp_occ  = 2'(occ);
    v.exp_rdy  = 1'(rdy);
    v.exp_data = DW'(d == d ? ed : 0);
    vecs.push_back(v);
  endfunction

  // Compare DUT outputs against the scoreboard queue.
  task automatic sb_check(input string tag);
    logic [CW-1:0] exp_ctrl;
    exp_ctrl = (q.size() > 0) ? q[0].ctrl : '0;
    chk({tag, " out_valid"}, 96'(out_valid), 96'(q.size() > 0));
    chk({tag, " in_ready"},  96'(in_ready),  96'(q.size() < 2));
    chk({tag, " occupancy"}, 96'(occupancy), 96'(q.size()));
    chk({tag, " out_ctrl"},  96'(out_ctrl),  96'(exp_ctrl));
    chk({tag, " out_data"},  96'(out_data),  96'(head_data));
`ifdef PIPE_SKID_STALL_CNT_EN
    chk({tag, " stall_cycles"}, 96'(stall_cycles), 96'(stall_m));
`endif
  endtask

  // Drive one cycle at the negedge, advance the model, check at the following negedge.
  task automatic step(input logic iv, input logic ordy, input logic fl,
                      input logic [CW-1:0] c, input logic [DW-1:0] d, input string tag);
    int    n;
    beat_t b;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_ctrl   = c;
    in_data   = d;
    n = q.size();
`ifdef PIPE_SKID_STALL_CNT_EN
    if (n > 0 && !ordy && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
`endif
    if (fl) begin
      q.delete();
    end else begin
      if (n > 0 && ordy) void'(q.pop_front());
      if (iv && n < 2) begin
        b.ctrl = c;
        b.data = d;
        q.push_back(b);
      end
    end
    if (q.size() > 0) head_data = q[0].data;
    @(negedge clk);
    sb_check(tag);
  endtask

  // One reset cycle, optionally with flush and a beat presented alongside.
  task automatic do_reset(input logic iv, input logic fl);
    rst       = 1'b1;
    in_valid  = iv;
    flush     = fl;
    out_ready = 1'b0;
    in_ctrl   = '1;
    in_data   = '1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    q.delete();
    head_data = '0;
`ifdef PIPE_SKID_STALL_CNT_EN
    stall_m = '0;
`endif
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    head_data = '0;
`ifdef PIPE_SKID_STALL_CNT_EN
    stall_m   = '0;
`endif

    // Streaming 1..8, then idle drain
    for (int k = 1; k <= 8; k++) add(1, 1, 0, 'h100 | k, k, 1, 1, k);
    add(0, 1, 0, 0, 0, 0, 1, 8);
    // Backpressure A, B, C held off, then release
    add(1, 0, 0, 'h011, 'h11, 1, 1, 'h11);
    add(1, 0, 0, 'h022, 'h22, 2, 0, 'h11);
    add(1, 0, 0, 'h033, 'h33, 2, 0, 'h11);
    add(1, 1, 0, 'h033, 'h33, 1, 1, 'h22);
    add(1, 1, 0, 'h033, 'h33, 1, 1, 'h33);
    add(0, 1, 0, 0, 0, 0, 1, 'h33);
    // Bubbles carrying all-ones control
    add(0, 1, 0, 'h1FF, 'h1234, 0, 1, 'h33);
    add(0, 0, 0, 'h1FF, 'h5678, 0, 1, 'h33);
    // Fill to FULL2, flush with D presented, then refill
    add(1, 0, 0, 'h044, 'h44, 1, 1, 'h44);
    add(1, 0, 0, 'h055, 'h55, 2, 0, 'h44);
    add(1, 0, 1, 'h066, 'h66, 0, 1, 'h44);
    add(0, 1, 0, 0, 0, 0, 1, 'h44);
    add(1, 1, 0, 'h077, 'h77, 1, 1, 'h77);
    add(0, 1, 0, 0, 0, 0, 1, 'h77);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb_check("reset");
    chk("reset out_data", 96'(out_data), 96'(0));
    chk("reset in_ready", 96'(in_ready), 96'(1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].ctrl, vecs[i].data, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_occ", i),  96'(occupancy), 96'(vecs[i].exp_occ));
      chk($sformatf("vec%0d tbl_rdy", i),  96'(in_ready),  96'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d tbl_data", i), 96'(out_data),  96'(vecs[i].exp_data));
      if (!vecs[i].exp_occ[0] && !vecs[i].exp_occ[1])
        chk($sformatf("vec%0d tbl_ctrl0", i), 96'(out_ctrl), 96'(0));
    end

    // Reset mid-stream while full, with flush and a beat presented
    step(1'b1, 1'b0, 1'b0, 9'h0AA, 69'hAA, "mr0");
    step(1'b1, 1'b0, 1'b0, 9'h0BB, 69'hBB, "mr1");
    chk("mr full", 96'(occupancy), 96'(2));
    do_reset(1'b1, 1'b1);
    sb_check("mr_reset");
    chk("mr out_data", 96'(out_data), 96'(0));
    chk("mr out_valid", 96'(out_valid), 96'(0));

`ifdef PIPE_SKID_STALL_CNT_EN
    // Five stalled cycles with a valid head
    step(1'b1, 1'b0, 1'b0, 9'h0C1, 69'hC1, "st_acc");
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, '0, '0, "st_hold");
    chk("stall five", 96'(stall_cycles), 96'(5));
    flush = 1'b0;
    repeat (65535) @(negedge clk);
    chk("stall sat", 96'(stall_cycles), 96'(16'hFFFF));
    stall_m = 16'hFFFF;
    step(1'b0, 1'b0, 1'b1, '0, '0, "st_flush");
    chk("stall after flush", 96'(stall_cycles), 96'(16'hFFFF));
    do_reset(1'b0, 1'b0);
    sb_check("st_reset");
`endif

    // Random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
           9'($urandom()), 69'({$urandom(), $urandom(), $urandom()}), $sformatf("rnd%0d", k));
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, '0, '0, "drain");
    chk("final occ", 96'(occupancy), 96'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed-field, stall-only stage registers (ID/EX, EX/MEM, MEM/WB) between CPU pipeline stages. The block adds three things those registers lack: backpressure with a registered upstream ready, a synchronous flush, and automatic clearing of control fields on bubbles. Payload is split into a control field (cleared when not valid) and a data field (held).

## Interface
- `DATA_W`, default 69: width of the data payload (for example ALU result, store data and rd).
- `CTRL_W`, default 9: width of the control payload (for example memread, memwrite, regwrite, memtoreg).
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `flush` input 1: discard all held entries (branch or trap redirect).
- `in_valid` input 1: upstream has a beat.
- `in_ready` output 1: block can accept a beat; driven directly from a flop.
- `in_ctrl` input CTRL_W: upstream control payload.
- `in_data` input DATA_W: upstream data payload.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: downstream accepts the head entry (the inverse of stall_CPU).
- `out_ctrl` output CTRL_W: head control payload; all zeros whenever out_valid=0.
- `out_data` output DATA_W: head data payload; holds its last value when out_valid=0.
- `occupancy` output 2: number of held entries, 0 to 2.
- `stall_cycles` output 16: present only with the macro; see Configuration.

## Operation
- Storage:
  - Head register: main_valid, main_ctrl, main_data.
  - Skid register: skid_valid, skid_ctrl, skid_data.
- Output mapping:
  - out_valid = main_valid.
  - out_ctrl = main_valid ? main_ctrl : 0.
  - out_data = main_data.
  - in_ready = !skid_valid.
- Accept: in_valid && in_ready. Drain: main_valid && out_ready.
- Per-cycle update, applied in priority order:
  1. rst: main_valid=0, skid_valid=0, main_ctrl=0, main_data=0, skid_ctrl=0, skid_data=0.
  2. flush: main_valid=0, skid_valid=0. Any beat presented this cycle is dropped. Data registers are not cleared.
  3. Head empty, or head draining:
     - If skid_valid: head loads from skid. If an accept also occurs, skid loads the input; otherwise skid_valid=0.
     - Else if accept: head loads the input.
     - Else: main_valid=0.
  4. Head full and not draining: an accept loads skid (skid_valid=1). Head holds.
- States, encoded by occupancy:
  - EMPTY (0): accept goes to FULL1.
  - FULL1 (1): accept without drain goes to FULL2; drain without accept goes to EMPTY; accept with drain stays in FULL1 (head replaced).
  - FULL2 (2): in_ready=0; drain goes to FULL1 (skid moves to head).
- Flush from any state goes to EMPTY.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost except on flush.

## Timing
- Reset values:
  - out_valid=0, out_ctrl=0, out_data=0.
  - in_ready=1 from the first cycle after rst is sampled.
  - occupancy=0, stall_cycles=0.
- Latency: a beat accepted in cycle N appears on out_valid in cycle N+1 when the head is empty or draining.
- Throughput: one beat per cycle when out_ready is held at 1.
- Backpressure:
  - in_ready falls one cycle after the skid fills. No beat is lost because the skid absorbs the beat that was in flight.
  - in_ready rises the cycle after the skid empties.
- There are no combinational paths from out_ready to in_ready or from in_valid to out_valid.
- Reset asserted mid-stream overrides flush and handshake in that cycle. Both entries are lost.
- Flush while in FULL2 gives in_ready=1 and out_valid=0 in the next cycle.

## Configuration
- `PIPE_SKID_STALL_CNT_EN`, when defined:
  - Adds output `stall_cycles[15:0]`.
  - Increments on every cycle with out_valid && !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by rst only; flush does not clear it.
- When the macro is undefined, the port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset, then idle:
  - Required: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Streaming: in_valid=1 with data 1..8, out_ready=1.
  - Required: out_data=1..8 on consecutive cycles, starting one cycle after the first accept; in_ready stays 1.
- Backpressure: out_ready=0 while beats A=0x11 and B=0x22 are presented.
  - Required: occupancy=2 and in_ready=0 the cycle after B is accepted; beat C is held off.
  - Then release out_ready. Required: output order A, B, C; occupancy returns to 0.
- Bubble control clear: in_ctrl=9'h1FF with in_valid=0.
  - Required: out_ctrl=0 and out_valid=0; out_data keeps the last accepted value.
- Flush in FULL2 with in_valid=1 presenting D on the same cycle.
  - Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; D never appears.
- With PIPE_SKID_STALL_CNT_EN defined: hold out_valid=1 and out_ready=0 for 5 cycles.
  - Required: stall_cycles=5.
  - Then preload the counter near saturation. Required: it holds at 16'hFFFF.
